// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if
// Shared SRAM-like bus between the arbiter and the SoC bus bridge.
//   m_req/m_wr/m_size/m_addr/m_wdata : request fields driven by the arbiter
//   m_addr_ok/m_data_ok/m_rdata      : responses driven by the bus bridge
// Modports:
//   master : arbiter side (drives the request fields)
//   slave  : bridge side (drives the responses)
interface mem_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              m_req;
  logic              m_wr;
  logic [1:0]        m_size;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic              m_addr_ok;
  logic              m_data_ok;
  logic [DATA_W-1:0] m_rdata;

  modport master (
    output m_req, m_wr, m_size, m_addr, m_wdata,
    input  m_addr_ok, m_data_ok, m_rdata
  );

  modport slave (
    input  m_req, m_wr, m_size, m_addr, m_wdata,
    output m_addr_ok, m_data_ok, m_rdata
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
// Shares one SRAM-like bus master port between the instruction-fetch
// requester (read-only) and the data-memory requester (load/store).
// One transaction is outstanding at a time; grant and bus request fields
// are registered, so requester inputs never reach m_* combinationally.
// Ports:
//   clk, resetn                  : clock, asynchronous active-low reset
//   i_req/i_addr                 : fetch request (held until i_addr_ok)
//   i_addr_ok/i_data_ok/i_rdata  : fetch responses (1-cycle pulses)
//   d_req/d_wr/d_size/d_addr/d_wdata : data request (held until d_addr_ok)
//   d_addr_ok/d_data_ok/d_rdata  : data responses (1-cycle pulses)
//   m_bus                        : bus master port (mem_bus_arbiter_if.master)
//   busy                         : transaction in flight
// Build option:
//   BUS_ARB_RR_EN : round-robin on ties (otherwise data beats inst).
module mem_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_addr_ok,
  output logic                i_data_ok,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic                d_wr,
  input  logic [1:0]          d_size,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_addr_ok,
  output logic                d_data_ok,
  output logic [DATA_W-1:0]   d_rdata,
  mem_bus_arbiter_if.master   m_bus,
  output logic                busy
);

  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic              owner_reg, owner_next;
  logic              wr_reg, wr_next;
  logic [1:0]        size_reg, size_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;
`ifdef BUS_ARB_RR_EN
  logic              last_owner_reg, last_owner_next;
`endif

  logic grant_data;
  logic addr_hs;
  logic data_hs;

  // Winner selection, only consulted in IDLE.
  always_comb begin
`ifdef BUS_ARB_RR_EN
    if (i_req && d_req) begin
      grant_data = (last_owner_reg == OWN_INST);
    end else begin
      grant_data = d_req;
    end
`else
    grant_data = d_req;
`endif
  end

  // Data response only counts in DATA, or in ADDR when it arrives together
  // with the address acceptance; anywhere else it is stray and ignored.
  assign addr_hs = (state_reg == ADDR) && m_bus.m_addr_ok;
  assign data_hs = ((state_reg == DATA) || addr_hs) && m_bus.m_data_ok;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg      <= IDLE;
      owner_reg      <= OWN_INST;
      wr_reg         <= 1'b0;
      size_reg       <= 2'd0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
`ifdef BUS_ARB_RR_EN
      last_owner_reg <= OWN_INST;
`endif
    end else begin
      state_reg      <= state_next;
      owner_reg      <= owner_next;
      wr_reg         <= wr_next;
      size_reg       <= size_next;
      addr_reg       <= addr_next;
      wdata_reg      <= wdata_next;
`ifdef BUS_ARB_RR_EN
      last_owner_reg <= last_owner_next;
`endif
    end
  end

  always_comb begin
    state_next      = state_reg;
    owner_next      = owner_reg;
    wr_next         = wr_reg;
    size_next       = size_reg;
    addr_next       = addr_reg;
    wdata_next      = wdata_reg;
`ifdef BUS_ARB_RR_EN
    last_owner_next = last_owner_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (i_req || d_req) begin
          state_next = ADDR;
          if (grant_data) begin
            owner_next = OWN_DATA;
            wr_next    = d_wr;
            size_next  = d_size;
            addr_next  = d_addr;
            wdata_next = d_wdata;
          end else begin
            owner_next = OWN_INST;
            wr_next    = 1'b0;
            size_next  = 2'd2;
            addr_next  = i_addr;
            wdata_next = '0;
          end
        end
      end
      ADDR: begin
        if (addr_hs) begin
          state_next = data_hs ? IDLE : DATA;
`ifdef BUS_ARB_RR_EN
          if (data_hs) last_owner_next = owner_reg;
`endif
        end
      end
      DATA: begin
        if (data_hs) begin
          state_next = IDLE;
`ifdef BUS_ARB_RR_EN
          last_owner_next = owner_reg;
`endif
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // m_req is a decode of the registered state, so it rises the cycle after
  // the grant and falls the cycle after m_addr_ok.
  assign m_bus.m_req   = (state_reg == ADDR);
  assign m_bus.m_wr    = wr_reg;
  assign m_bus.m_size  = size_reg;
  assign m_bus.m_addr  = addr_reg;
  assign m_bus.m_wdata = wdata_reg;

  assign i_addr_ok = addr_hs && (owner_reg == OWN_INST);
  assign d_addr_ok = addr_hs && (owner_reg == OWN_DATA);
  assign i_data_ok = data_hs && (owner_reg == OWN_INST);
  assign d_data_ok = data_hs && (owner_reg == OWN_DATA);
  assign i_rdata   = i_data_ok ? m_bus.m_rdata : '0;
  assign d_rdata   = d_data_ok ? m_bus.m_rdata : '0;
  assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;
  logic        clk = 1'b0;
  logic        resetn;
  logic        i_req, i_addr_ok, i_data_ok;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_wr, d_addr_ok, d_data_ok;
  logic [1:0]  d_size;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        busy;

  int errors = 0;
  int checks = 0;

  mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .resetn(resetn),
    .i_req(i_req), .i_addr(i_addr), .i_addr_ok(i_addr_ok),
    .i_data_ok(i_data_ok), .i_rdata(i_rdata),
    .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok),
    .d_rdata(d_rdata), .m_bus(bus), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic i_req; logic [31:0] i_addr;
    logic d_req; logic d_wr; logic [1:0] d_size; logic [31:0] d_addr; logic [31:0] d_wdata;
    logic aok; logic dok; logic [31:0] rdata;
    logic e_req; logic e_fld; logic e_wr; logic [1:0] e_size; logic [31:0] e_addr; logic [31:0] e_wdata;
    logic e_iaok; logic e_idok; logic [31:0] e_irdata; logic e_daok; logic e_ddok; logic e_busy;
  } vec_t;

  vec_t vt [11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    i_req = 0; i_addr = 0; d_req = 0; d_wr = 0; d_size = 0; d_addr = 0; d_wdata = 0;
    bus.m_addr_ok = 0; bus.m_data_ok = 0; bus.m_rdata = 0;
  endtask

  task automatic set_in(input int k, input logic ir, input logic [31:0] ia,
                        input logic dr, input logic dw, input logic [1:0] ds,
                        input logic [31:0] da, input logic [31:0] dd,
                        input logic aok, input logic dok, input logic [31:0] rd);
    vt[k].i_req = ir; vt[k].i_addr = ia; vt[k].d_req = dr; vt[k].d_wr = dw;
    vt[k].d_size = ds; vt[k].d_addr = da; vt[k].d_wdata = dd;
    vt[k].aok = aok; vt[k].dok = dok; vt[k].rdata = rd;
  endtask

  task automatic set_exp(input int k, input logic rq, input logic fl, input logic wr,
                         input logic [1:0] sz, input logic [31:0] ad, input logic [31:0] wd,
                         input logic iaok, input logic idok, input logic [31:0] ird,
                         input logic daok, input logic ddok, input logic bz);
    vt[k].e_req = rq; vt[k].e_fld = fl; vt[k].e_wr = wr; vt[k].e_size = sz;
    vt[k].e_addr = ad; vt[k].e_wdata = wd; vt[k].e_iaok = iaok; vt[k].e_idok = idok;
    vt[k].e_irdata = ird; vt[k].e_daok = daok; vt[k].e_ddok = ddok; vt[k].e_busy = bz;
  endtask

  // One bus transaction for whichever requester the arbitration rule picks.
  // Entered in an IDLE cycle with the requests already driven.
  task automatic do_txn(input bit exp_d, input bit drop, input logic [31:0] rd, input string tag);
    @(negedge clk);
    bus.m_addr_ok = 1; #1;
    chk({tag, ".m_req"}, bus.m_req, 1);
    chk({tag, ".m_addr"}, bus.m_addr, exp_d ? d_addr : i_addr);
    chk({tag, ".i_addr_ok"}, i_addr_ok, !exp_d);
    chk({tag, ".d_addr_ok"}, d_addr_ok, exp_d);
    @(negedge clk);
    bus.m_addr_ok = 0; bus.m_data_ok = 1; bus.m_rdata = rd;
    if (drop) begin
      if (exp_d) d_req = 0; else i_req = 0;
    end
    #1;
    chk({tag, ".i_data_ok"}, i_data_ok, !exp_d);
    chk({tag, ".d_data_ok"}, d_data_ok, exp_d);
    chk({tag, ".i_rdata"}, i_rdata, exp_d ? 32'h0 : rd);
    chk({tag, ".d_rdata"}, d_rdata, exp_d ? rd : 32'h0);
    $display("txn %s owner=%s rdata=%h", tag, exp_d ? "data" : "inst", rd);
    @(negedge clk);
    bus.m_data_ok = 0; bus.m_rdata = 0; #1;
    chk({tag, ".busy_idle"}, busy, 0);
    chk({tag, ".m_req_idle"}, bus.m_req, 0);
  endtask

  // Random-phase model state
  int          phase;
  bit          ip, dp, own, last, grant_pend, g_own, aok, dok, w;
  int          ph_now;
  logic        e_wr, g_wr;
  logic [1:0]  e_size, g_size;
  logic [31:0] e_addr, e_wdata, g_addr, g_wdata;

  initial begin
    clear_inputs();
    resetn = 0;
    @(negedge clk); #1;
    chk("rst.m_req", bus.m_req, 0);
    chk("rst.m_wr", bus.m_wr, 0);
    chk("rst.m_size", bus.m_size, 0);
    chk("rst.m_addr", bus.m_addr, 0);
    chk("rst.m_wdata", bus.m_wdata, 0);
    chk("rst.busy", busy, 0);
    chk("rst.pulses", {i_addr_ok, i_data_ok, d_addr_ok, d_data_ok}, 0);
    chk("rst.rdata", {i_rdata, d_rdata}, 0);
    resetn = 1;

    // Fetch then store, cycle by cycle.
    set_in(0, 1, 32'hBFC00000, 0, 0, 0, 0, 0, 0, 0, 0);
    set_exp(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_in(1, 1, 32'hBFC00000, 0, 0, 0, 0, 0, 0, 0, 0);
    set_exp(1, 1, 1, 0, 2, 32'hBFC00000, 0, 0, 0, 0, 0, 0, 1);
    set_in(2, 1, 32'hBFC00000, 0, 0, 0, 0, 0, 0, 0, 0);
    set_exp(2, 1, 1, 0, 2, 32'hBFC00000, 0, 0, 0, 0, 0, 0, 1);
    set_in(3, 1, 32'hBFC00000, 0, 0, 0, 0, 0, 1, 0, 0);
    set_exp(3, 1, 1, 0, 2, 32'hBFC00000, 0, 1, 0, 0, 0, 0, 1);
    set_in(4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h55555555);
    set_exp(4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    set_in(5, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h24080001);
    set_exp(5, 0, 0, 0, 0, 0, 0, 0, 1, 32'h24080001, 0, 0, 1);
    set_in(6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_exp(6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_in(7, 0, 0, 1, 1, 0, 32'h80000003, 32'hAB, 0, 0, 0);
    set_exp(7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_in(8, 0, 0, 1, 1, 0, 32'h80000003, 32'hAB, 1, 0, 0);
    set_exp(8, 1, 1, 1, 0, 32'h80000003, 32'hAB, 0, 0, 0, 1, 0, 1);
    set_in(9, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h12345678);
    set_exp(9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    set_in(10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_exp(10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    @(negedge clk);
    for (int k = 0; k < 11; k++) begin
      i_req = vt[k].i_req; i_addr = vt[k].i_addr; d_req = vt[k].d_req; d_wr = vt[k].d_wr;
      d_size = vt[k].d_size; d_addr = vt[k].d_addr; d_wdata = vt[k].d_wdata;
      bus.m_addr_ok = vt[k].aok; bus.m_data_ok = vt[k].dok; bus.m_rdata = vt[k].rdata;
      #1;
      chk($sformatf("v%0d.m_req", k), bus.m_req, vt[k].e_req);
      if (vt[k].e_fld) begin
        chk($sformatf("v%0d.m_wr", k), bus.m_wr, vt[k].e_wr);
        chk($sformatf("v%0d.m_size", k), bus.m_size, vt[k].e_size);
        chk($sformatf("v%0d.m_addr", k), bus.m_addr, vt[k].e_addr);
        chk($sformatf("v%0d.m_wdata", k), bus.m_wdata, vt[k].e_wdata);
      end
      chk($sformatf("v%0d.i_addr_ok", k), i_addr_ok, vt[k].e_iaok);
      chk($sformatf("v%0d.i_data_ok", k), i_data_ok, vt[k].e_idok);
      chk($sformatf("v%0d.i_rdata", k), i_rdata, vt[k].e_irdata);
      chk($sformatf("v%0d.d_addr_ok", k), d_addr_ok, vt[k].e_daok);
      chk($sformatf("v%0d.d_data_ok", k), d_data_ok, vt[k].e_ddok);
      if (!vt[k].e_ddok) chk($sformatf("v%0d.d_rdata", k), d_rdata, 0);
      chk($sformatf("v%0d.busy", k), busy, vt[k].e_busy);
      if (vt[k].e_idok || vt[k].e_ddok)
        $display("txn vec%0d owner=%s rdata=%h", k, vt[k].e_idok ? "inst" : "data", vt[k].rdata);
      @(negedge clk);
    end
    clear_inputs();

    // Tie: data first, inst second, then a repeated tie.
    i_req = 1; i_addr = 32'h1000; d_req = 1; d_wr = 0; d_size = 2; d_addr = 32'h2000;
    do_txn(1, 1, 32'hA0000001, "tie0");
    do_txn(0, 0, 32'hA0000002, "tie1");
    d_req = 1;
    for (int j = 0; j < 4; j++) begin
`ifdef BUS_ARB_RR_EN
      do_txn((j % 2) == 0, 0, 32'hB0000000 + j, $sformatf("rr%0d", j));
`else
      do_txn(1, 0, 32'hB0000000 + j, $sformatf("rr%0d", j));
`endif
    end
    clear_inputs();
    @(negedge clk);

    // m_addr_ok and m_data_ok together in ADDR.
    i_req = 1; i_addr = 32'h3000;
    @(negedge clk);
    bus.m_addr_ok = 1; bus.m_data_ok = 1; bus.m_rdata = 32'hCAFE0001;
    d_req = 1; d_wr = 1; d_size = 1; d_addr = 32'h4000; d_wdata = 32'h77;
    #1;
    chk("both.i_addr_ok", i_addr_ok, 1);
    chk("both.i_data_ok", i_data_ok, 1);
    chk("both.i_rdata", i_rdata, 32'hCAFE0001);
    chk("both.d_pulses", {d_addr_ok, d_data_ok}, 0);
    $display("txn both owner=inst rdata=cafe0001");
    @(negedge clk);
    i_req = 0; bus.m_addr_ok = 0; bus.m_data_ok = 0; bus.m_rdata = 0; #1;
    chk("both.busy_idle", busy, 0);
    chk("both.m_req_gap", bus.m_req, 0);
    @(negedge clk);
    bus.m_addr_ok = 1; bus.m_data_ok = 1; #1;
    chk("both.next_m_req", bus.m_req, 1);
    chk("both.next_fields", {bus.m_wr, bus.m_size, bus.m_addr, bus.m_wdata}, {1'b1, 2'd1, 32'h4000, 32'h77});
    chk("both.d_pulses2", {d_addr_ok, d_data_ok}, 2'b11);
    $display("txn both2 owner=data store addr=00004000");
    @(negedge clk);
    clear_inputs(); #1;
    chk("both.busy_end", busy, 0);

    // Reset while in DATA.
    @(negedge clk);
    i_req = 1; i_addr = 32'h5000;
    @(negedge clk);
    bus.m_addr_ok = 1;
    @(negedge clk);
    i_req = 0; bus.m_addr_ok = 0; #1;
    chk("rstd.busy_data", busy, 1);
    resetn = 0; bus.m_data_ok = 1; bus.m_rdata = 32'h99; #1;
    chk("rstd.m_bus", {bus.m_req, bus.m_wr, bus.m_size, bus.m_addr, bus.m_wdata}, 0);
    chk("rstd.busy", busy, 0);
    chk("rstd.pulses", {i_addr_ok, i_data_ok, d_addr_ok, d_data_ok}, 0);
    chk("rstd.rdata", {i_rdata, d_rdata}, 0);
    @(negedge clk);
    resetn = 1; bus.m_data_ok = 0;
    @(negedge clk);
    bus.m_data_ok = 1; bus.m_rdata = 32'h99; #1;
    chk("rstd.no_data_ok", {i_data_ok, d_data_ok}, 0);
    chk("rstd.rdata_after", {i_rdata, d_rdata}, 0);
    chk("rstd.busy_after", busy, 0);
    $display("txn reset_abandon inst addr=00005000");
    clear_inputs();

    // Stray responses while IDLE.
    @(negedge clk);
    bus.m_data_ok = 1; bus.m_addr_ok = 1; bus.m_rdata = 32'hDEADBEEF; #1;
    chk("spur.pulses", {i_addr_ok, i_data_ok, d_addr_ok, d_data_ok}, 0);
    chk("spur.i_rdata", i_rdata, 0);
    chk("spur.d_rdata", d_rdata, 0);
    @(negedge clk);
    #1;
    chk("spur.busy", busy, 0);
    $display("txn spurious rdata=deadbeef ignored");
    clear_inputs();

    // Randomized traffic against a transaction-level model.
    resetn = 0;
    @(negedge clk);
    resetn = 1;
    phase = 0; ip = 0; dp = 0; own = 0; last = 0; grant_pend = 0;
    e_wr = 0; e_size = 0; e_addr = 0; e_wdata = 0;
    @(negedge clk);
    for (int c = 0; c < 1500; c++) begin
      if (grant_pend) begin
        phase = 1; own = g_own; e_wr = g_wr; e_size = g_size; e_addr = g_addr; e_wdata = g_wdata;
        grant_pend = 0;
      end
      if (!ip && $urandom_range(0, 2) == 0) begin ip = 1; i_addr = $urandom; end
      if (!dp && $urandom_range(0, 2) == 0) begin
        dp = 1; d_wr = 1'($urandom_range(0, 1)); d_size = 2'($urandom_range(0, 2));
        d_addr = $urandom; d_wdata = $urandom;
      end
      i_req = ip; d_req = dp;
      bus.m_addr_ok = ($urandom_range(0, 2) == 0);
      bus.m_data_ok = ($urandom_range(0, 2) == 0);
      bus.m_rdata = $urandom;
      #1;
      aok = (phase == 1) && bus.m_addr_ok;
      dok = bus.m_data_ok && ((phase == 2) || aok);
      chk("rnd.m_req", bus.m_req, phase == 1);
      chk("rnd.busy", busy, phase != 0);
      if (phase == 1)
        chk("rnd.fields", {bus.m_wr, bus.m_size, bus.m_addr, bus.m_wdata}, {e_wr, e_size, e_addr, e_wdata});
      chk("rnd.i_addr_ok", i_addr_ok, aok && !own);
      chk("rnd.d_addr_ok", d_addr_ok, aok && own);
      chk("rnd.i_data_ok", i_data_ok, dok && !own);
      chk("rnd.d_data_ok", d_data_ok, dok && own);
      chk("rnd.i_rdata", i_rdata, (dok && !own) ? bus.m_rdata : 32'h0);
      if (!(dok && own && e_wr))
        chk("rnd.d_rdata", d_rdata, (dok && own) ? bus.m_rdata : 32'h0);
      if (dok)
        $display("txn rnd owner=%s wr=%0d size=%0d addr=%h rdata=%h",
                 own ? "data" : "inst", e_wr, e_size, e_addr, bus.m_rdata);
      ph_now = phase;
      if (aok) begin
        if (own) dp = 0; else ip = 0;
      end
      if (dok) begin phase = 0; last = own; end
      else if (aok) phase = 2;
      if (ph_now == 0 && (ip || dp)) begin
`ifdef BUS_ARB_RR_EN
        w = (ip && dp) ? !last : dp;
`else
        w = dp;
`endif
        grant_pend = 1; g_own = w;
        if (w) begin g_wr = d_wr; g_size = d_size; g_addr = d_addr; g_wdata = d_wdata; end
        else begin g_wr = 0; g_size = 2; g_addr = i_addr; g_wdata = 0; end
      end
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
